// File: rtl/grid_game_engine.sv
// Grid game engine: an LFSR-driven fire field, gold spawn/expiry/catch, lives and score,
// sequenced by an INIT/PLAY/PAUSE/FINISH state machine. All outputs are registers.
//
//   state  | meaning
//   INIT   | game parameters held at reset values, waiting for start
//   PLAY   | fire advances on tick, collisions and catches between ticks
//   PAUSE  | everything frozen until the next pause pulse
//   FINISH | out of lives or max score reached; start returns to INIT
module grid_game_engine #(
  parameter int               CELLS     = 9,
  parameter int               LIFE_MAX  = 3,
  parameter int               SCORE_MAX = 5,
  parameter logic [CELLS-1:0] SEED      = 9'b100110110,
  parameter logic [CELLS-1:0] TAPS      = 9'b001101000,
  parameter int               GOLD_GAP  = 3,
  parameter int               GOLD_LIFE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             super_i,
  input  logic [CELLS-1:0] box_i,
  output logic [1:0]       game_state_o,
  output logic [CELLS-1:0] fire_state_o,
  output logic [CELLS-1:0] gold_state_o,
  output logic [3:0]       life_o,
  output logic [7:0]       score_o,
  output logic             win_o,
  output logic             hit_pulse_o
);
  localparam int PW = $clog2(CELLS);
  localparam int GW = (GOLD_GAP > 1) ? $clog2(GOLD_GAP + 1) : 1;
  localparam int AW = (GOLD_LIFE > 1) ? $clog2(GOLD_LIFE) : 1;

  localparam logic [3:0]    LIFE_INIT = 4'(LIFE_MAX);
  localparam logic [7:0]    SMAX      = 8'(SCORE_MAX);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GOLD_GAP);
  localparam logic [AW-1:0] AGE_LAST  = AW'(GOLD_LIFE - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(CELLS - 1);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_PLAY   = 2'd1,
    S_FINISH = 2'd2,
    S_PAUSE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CELLS-1:0] fire_q, fire_d;
  logic [CELLS-1:0] hit_q, hit_d;
  logic [CELLS-1:0] fire_vis_q, fire_vis_d;
  logic [CELLS-1:0] gold_q, gold_d;
  logic [3:0]       life_q, life_d;
  logic [7:0]       score_q, score_d;
  logic             win_q, win_d;
  logic             pulse_q, pulse_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [AW-1:0]    age_q, age_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic [CELLS-1:0] fire_nxt;
  logic [CELLS-1:0] hits;
  logic [5:0]       hit_cnt;
  logic [CELLS-1:0] spawn_vec;
  logic             spawn_found;
  logic [GW-1:0]    gap_inc;
  logic             load_init;

  assign fire_nxt = {fire_q[0], fire_q[CELLS-1:1]}
                  ^ ({1'b0, TAPS[CELLS-2:0]} & {CELLS{fire_q[0]}});
  // Gold cells never count as hits, and already-hit cells are masked out of fire_vis_q.
  assign hits     = box_i & fire_vis_q & ~gold_q;
  assign gap_inc  = (gap_q == GAP_MAX) ? GAP_MAX : gap_q + 1'b1;

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < CELLS; i++) hit_cnt = hit_cnt + 6'(hits[i]);
  end

  // Two passes give a wrapping search that starts at the spawn pointer.
  always_comb begin
    spawn_found = 1'b0;
    spawn_vec   = '0;
    for (int c = 0; c < CELLS; c++) begin
      if (!spawn_found && c >= int'(ptr_q) && !fire_nxt[c]) begin
        spawn_found  = 1'b1;
        spawn_vec[c] = 1'b1;
      end
    end
    for (int c = 0; c < CELLS; c++) begin
      if (!spawn_found && c < int'(ptr_q) && !fire_nxt[c]) begin
        spawn_found  = 1'b1;
        spawn_vec[c] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    fire_d    = fire_q;
    hit_d     = hit_q;
    gold_d    = gold_q;
    life_d    = life_q;
    score_d   = score_q;
    win_d     = win_q;
    pulse_d   = 1'b0;
    gap_d     = gap_q;
    age_d     = age_q;
    ptr_d     = ptr_q;
    load_init = 1'b0;
    unique case (state_q)
      S_INIT: begin
        load_init = 1'b1;
        if (start_i) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (life_q == 4'd0 || score_q == SMAX) begin
          state_d = S_FINISH;
          win_d   = (score_q == SMAX);
        end else begin
          if (pause_i) state_d = S_PAUSE;
          if (tick_i) begin
            fire_d = fire_nxt;
            hit_d  = '0;
            ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
            if (gold_q != '0) begin
              // Early clear if the advancing fire would land on the gold cell.
              if (age_q == AGE_LAST || (fire_nxt & gold_q) != '0) begin
                gold_d = '0;
                age_d  = '0;
              end else begin
                age_d = age_q + 1'b1;
              end
            end else begin
              gap_d = gap_inc;
              if (gap_inc == GAP_MAX && spawn_found) begin
                gold_d = spawn_vec;
                gap_d  = '0;
                age_d  = '0;
              end
            end
          end else begin
            if (!super_i && hits != '0) begin
              hit_d   = hit_q | hits;
              life_d  = (hit_cnt >= {2'b00, life_q}) ? 4'd0 : life_q - hit_cnt[3:0];
              pulse_d = 1'b1;
            end
            if ((box_i & gold_q) != '0) begin
              score_d = (score_q == SMAX) ? SMAX : score_q + 8'd1;
              gold_d  = '0;
              gap_d   = '0;
              age_d   = '0;
            end
          end
        end
      end
      S_PAUSE: begin
        if (pause_i) state_d = S_PLAY;
      end
      S_FINISH: begin
        if (start_i) begin
          state_d   = S_INIT;
          load_init = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
    if (load_init) begin
      fire_d  = SEED;
      hit_d   = '0;
      gold_d  = '0;
      life_d  = LIFE_INIT;
      score_d = '0;
      win_d   = 1'b0;
      gap_d   = '0;
      age_d   = '0;
      ptr_d   = '0;
    end
    fire_vis_d = fire_d & ~hit_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      fire_q     <= SEED;
      hit_q      <= '0;
      fire_vis_q <= SEED;
      gold_q     <= '0;
      life_q     <= LIFE_INIT;
      score_q    <= '0;
      win_q      <= 1'b0;
      pulse_q    <= 1'b0;
      gap_q      <= '0;
      age_q      <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      fire_q     <= fire_d;
      hit_q      <= hit_d;
      fire_vis_q <= fire_vis_d;
      gold_q     <= gold_d;
      life_q     <= life_d;
      score_q    <= score_d;
      win_q      <= win_d;
      pulse_q    <= pulse_d;
      gap_q      <= gap_d;
      age_q      <= age_d;
      ptr_q      <= ptr_d;
    end
  end

  assign game_state_o = state_q;
  assign fire_state_o = fire_vis_q;
  assign gold_state_o = gold_q;
  assign life_o       = life_q;
  assign score_o      = score_q;
  assign win_o        = win_q;
  assign hit_pulse_o  = pulse_q;

endmodule

// File: tb/tb_grid_game_engine.sv
// Bench for grid_game_engine: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural game model.
module tb_grid_game_engine;
  localparam int CELLS     = 9;
  localparam int LIFE_MAX  = 3;
  localparam int SCORE_MAX = 5;
  localparam int SEED_I    = 'b100110110;
  localparam int TAPS_I    = 'b001101000;
  localparam int GOLD_GAP  = 3;
  localparam int GOLD_LIFE = 1;
  localparam int MASK      = (1 << CELLS) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick = 1'b0, start = 1'b0, pause = 1'b0, sup = 1'b0;
  logic [CELLS-1:0] box = '0;
  logic [1:0]       game_state;
  logic [CELLS-1:0] fire_state, gold_state;
  logic [3:0]       life;
  logic [7:0]       score;
  logic             win, hit_pulse;

  logic             f_tick = 1'b0, f_start = 1'b0;
  logic [1:0]       f_game_state;
  logic [CELLS-1:0] f_fire_state, f_gold_state;
  logic [3:0]       f_life;
  logic [7:0]       f_score;
  logic             f_win, f_hit_pulse;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Behavioural game model (state encoded as the output code 0..3)
  int m_state, m_fire, m_hit, m_gold, m_life, m_score, m_win, m_pulse, m_gap, m_age, m_ptr;

  grid_game_engine #(
    .CELLS(CELLS), .LIFE_MAX(LIFE_MAX), .SCORE_MAX(SCORE_MAX),
    .SEED(9'b100110110), .TAPS(9'b001101000), .GOLD_GAP(GOLD_GAP), .GOLD_LIFE(GOLD_LIFE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .start_i(start), .pause_i(pause),
    .super_i(sup), .box_i(box), .game_state_o(game_state), .fire_state_o(fire_state),
    .gold_state_o(gold_state), .life_o(life), .score_o(score), .win_o(win),
    .hit_pulse_o(hit_pulse)
  );

  grid_game_engine #(
    .CELLS(CELLS), .LIFE_MAX(LIFE_MAX), .SCORE_MAX(SCORE_MAX),
    .SEED(9'h1FF), .TAPS(9'h000), .GOLD_GAP(GOLD_GAP), .GOLD_LIFE(GOLD_LIFE)
  ) dut_fire (
    .clk(clk), .rst_n(rst_n), .tick_i(f_tick), .start_i(f_start), .pause_i(1'b0),
    .super_i(1'b0), .box_i('0), .game_state_o(f_game_state), .fire_state_o(f_fire_state),
    .gold_state_o(f_gold_state), .life_o(f_life), .score_o(f_score), .win_o(f_win),
    .hit_pulse_o(f_hit_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lfsr(input int f);
    int b0, r;
    b0 = f & 1;
    r  = (f >> 1) | (b0 << (CELLS - 1));
    if (b0 != 0) r = r ^ (TAPS_I & ((1 << (CELLS - 1)) - 1));
    return r & MASK;
  endfunction

  task automatic model_init();
    m_fire = SEED_I; m_hit = 0; m_gold = 0; m_life = LIFE_MAX; m_score = 0;
    m_win = 0; m_gap = 0; m_age = 0; m_ptr = 0;
  endtask

  task automatic model_step();
    int nf, hits, c, bx;
    bit found;
    bx = int'(box);
    m_pulse = 0;
    case (m_state)
      0: begin
        model_init();
        if (start) m_state = 1;
      end
      1: begin
        if (m_life == 0 || m_score == SCORE_MAX) begin
          m_state = 2;
          m_win = (m_score == SCORE_MAX) ? 1 : 0;
        end else begin
          if (pause) m_state = 3;
          if (tick) begin
            nf = lfsr(m_fire);
            if (m_gold != 0) begin
              m_age++;
              if (m_age >= GOLD_LIFE || (nf & m_gold) != 0) begin m_gold = 0; m_age = 0; end
            end else begin
              if (m_gap < GOLD_GAP) m_gap++;
              if (m_gap == GOLD_GAP) begin
                found = 0;
                for (int k = 0; k < CELLS; k++) begin
                  c = (m_ptr + k) % CELLS;
                  if (!found && ((nf >> c) & 1) == 0) begin
                    found = 1; m_gold = 1 << c; m_gap = 0; m_age = 0;
                  end
                end
              end
            end
            m_fire = nf; m_hit = 0; m_ptr = (m_ptr + 1) % CELLS;
          end else begin
            hits = bx & m_fire & ~m_hit & ~m_gold & MASK;
            if (!sup && hits != 0) begin
              m_hit = m_hit | hits;
              m_life = m_life - $countones(hits);
              if (m_life < 0) m_life = 0;
              m_pulse = 1;
            end
            if ((bx & m_gold) != 0) begin
              if (m_score < SCORE_MAX) m_score++;
              m_gold = 0; m_gap = 0; m_age = 0;
            end
          end
        end
      end
      2: if (start) begin m_state = 0; model_init(); end
      default: if (pause) m_state = 1;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_pulse = 0; model_init();
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("game_state", int'(game_state), m_state);
      chk("fire_state", int'(fire_state), m_fire & ~m_hit & MASK);
      chk("gold_state", int'(gold_state), m_gold);
      chk("life", int'(life), m_life);
      chk("score", int'(score), m_score);
      chk("win", int'(win), m_win);
      chk("hit_pulse", int'(hit_pulse), m_pulse);
      if ((int'(gold_state) & int'(fire_state)) != 0) chk("gold_fire_overlap", 1, 0);
    end
  end

  task automatic step(input bit t, input bit s, input bit p, input bit su, input logic [CELLS-1:0] b);
    tick = t; start = s; pause = p; sup = su; box = b;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0);
  endtask

  task automatic catch_gold();
    int n;
    n = 0;
    while (m_gold == 0 && n < 40) begin
      step(1, 0, 0, 0, '0);
      n++;
    end
    if (m_gold == 0) begin
      checks++; failures++;
      $display("FAIL gold_spawn_timeout actual=none required=spawn within 40 ticks");
    end else begin
      step(0, 0, 0, 0, CELLS'(m_gold));
    end
  endtask

  task automatic hit_cells(input int n);
    int vis, sel, cnt, tries;
    tries = 0;
    vis = m_fire & ~m_hit & ~m_gold & MASK;
    while ($countones(vis) < n && tries < 20) begin
      step(1, 0, 0, 0, '0);
      tries++;
      vis = m_fire & ~m_hit & ~m_gold & MASK;
    end
    sel = 0; cnt = 0;
    for (int c = 0; c < CELLS; c++) begin
      if (cnt < n && ((vis >> c) & 1) != 0) begin sel = sel | (1 << c); cnt++; end
    end
    step(0, 0, 0, 0, CELLS'(sel));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [CELLS-1:0] b;
    bit t, s, p, su;

    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    rst_n = 1'b1;
    idle();
    chk("rst_state", int'(game_state), 0);
    chk("rst_fire", int'(fire_state), 'b100110110);
    chk("rst_life", int'(life), 3);
    chk("rst_score", int'(score), 0);

    // All-fire field never leaves room for gold
    f_start = 1'b1; idle(); f_start = 1'b0;
    chk("allfire_state", int'(f_game_state), 1);
    for (int i = 0; i < 11; i++) begin
      f_tick = 1'b1; idle(); f_tick = 1'b0;
      chk("allfire_gold", int'(f_gold_state), 0);
      chk("allfire_fire", int'(f_fire_state), 'h1FF);
    end

    step(0, 1, 0, 0, '0);
    chk("play_state", int'(game_state), 1);
    step(1, 0, 0, 0, '0);
    chk("tick1_fire", int'(fire_state), 'b010011011);
    step(0, 0, 1, 0, '0);
    chk("pause_state", int'(game_state), 3);
    step(1, 0, 0, 0, '0);
    chk("pause_tick_fire", int'(fire_state), 'b010011011);
    step(0, 0, 1, 0, '0);
    chk("resume_state", int'(game_state), 1);

    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 9'b000000010);
      pulses += int'(hit_pulse);
    end
    chk("single_hit_life", int'(life), 2);
    chk("single_hit_pulses", pulses, 1);
    chk("single_hit_fire", int'(fire_state), 'b010011001);
    step(1, 0, 0, 0, '0);
    chk("tick2_fire", int'(fire_state), 'b100100101);

    step(0, 0, 0, 1, 9'b100100001);
    chk("super_life", int'(life), 2);
    chk("super_pulse", int'(hit_pulse), 0);
    step(0, 0, 0, 0, 9'b100100001);
    chk("triple_hit_life", int'(life), 0);
    chk("triple_hit_pulse", int'(hit_pulse), 1);
    chk("triple_hit_fire", int'(fire_state), 'b000000100);
    idle();
    chk("dead_state", int'(game_state), 2);
    chk("dead_win", int'(win), 0);
    step(0, 1, 0, 0, '0);
    chk("restart_state", int'(game_state), 0);
    chk("restart_life", int'(life), 3);

    step(0, 1, 0, 0, '0);
    for (int i = 0; i < 5; i++) catch_gold();
    chk("five_catch_score", int'(score), 5);
    idle();
    chk("win_state", int'(game_state), 2);
    chk("win_flag", int'(win), 1);
    step(0, 1, 0, 0, '0);
    chk("win_restart_state", int'(game_state), 0);
    chk("win_restart_win", int'(win), 0);

    step(0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) catch_gold();
    hit_cells(2);
    chk("pre_reset_life", int'(life), 1);
    chk("pre_reset_score", int'(score), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(game_state), 0);
    chk("async_rst_life", int'(life), 3);
    chk("async_rst_score", int'(score), 0);
    chk("async_rst_fire", int'(fire_state), 'b100110110);
    chk("async_rst_pulse", int'(hit_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    for (int i = 0; i < 2500; i++) begin
      t  = ($urandom_range(0, 99) < 30);
      s  = ($urandom_range(0, 15) == 0);
      p  = ($urandom_range(0, 19) == 0);
      su = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) b = CELLS'(m_gold);
      else b = CELLS'($urandom & $urandom);
      step(t, s, p, su, b);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/grid_game_engine.md
GRID_GAME_ENGINE -- requirements
Module: grid_game_engine

Interface
REQ-001 Parameters (name, default, meaning):
- CELLS, 9, grid cell count (2..32).
- LIFE_MAX, 3, starting lives (1..15).
- SCORE_MAX, 5, winning score (1..255).
- SEED, 9'b100110110, fire LFSR reset/INIT value (CELLS bits, nonzero).
- TAPS, 9'b001101000, fire LFSR feedback mask (CELLS bits).
- GOLD_GAP, 3, ticks without gold before a spawn attempt (>=1).
- GOLD_LIFE, 1, ticks a spawned gold persists (>=1).

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- tick, in, 1, one-cycle game-step strobe.
- start, in, 1, one-cycle start/advance pulse.
- pause, in, 1, one-cycle pause toggle pulse.
- super, in, 1, invincibility level.
- box, in, CELLS, player-occupied cells.
- game_state, out, 2, state: INIT=0, PLAY=1, FINISH=2, PAUSE=3.
- fire_state, out, CELLS, visible fire: fire_pattern & ~hit_bitmap.
- gold_state, out, CELLS, one-hot gold cell or zero.
- life, out, 4, remaining lives.
- score, out, 8, gold caught.
- win, out, 1, high in FINISH when score==SCORE_MAX.
- hit_pulse, out, 1, one-cycle high on the cycle after any life loss.

REQ-003 All outputs SHALL be driven from registers only; no combinational path from any input to any output.

Function
REQ-004 State transitions, taking effect on the next edge:
- INIT->PLAY on start.
- PLAY->FINISH when life==0 or score==SCORE_MAX.
- PLAY->PAUSE on pause.
- PAUSE->PLAY on pause.
- FINISH->INIT on start.
- start in PLAY or PAUSE is ignored.
REQ-005 In INIT: fire_pattern=SEED, hit_bitmap=0, gold_state=0, life=LIFE_MAX, score=0, win=0, gold counters=0, spawn pointer=0.
REQ-006 Fire LFSR advances only on tick in PLAY:
- new[CELLS-1] = old[0].
- For k<CELLS-1: new[k] = old[k+1] ^ (TAPS[k] & old[0]).
- hit_bitmap clears on the same edge.
REQ-007 In PAUSE and FINISH: tick is ignored; fire, gold, life and score hold.
REQ-008 Collision is evaluated in PLAY on non-tick cycles only, with hits = box & fire_state & ~gold_state:
- If super=0, each hit cell sets its hit_bitmap bit.
- life decrements by popcount(hits), saturating at 0.
- hit_pulse asserts next cycle.
- A cell therefore costs at most one life per tick interval.
REQ-009 With super=1: no life loss, no hit_bitmap update, no hit_pulse.
REQ-010 Gold spawn:
- While gold_state==0 in PLAY, a gap counter increments per tick.
- On the tick where the counter reaches GOLD_GAP, the engine scans cells from the spawn pointer upward, wrapping, for the first cell with next-pattern fire bit 0; it places gold there and clears the counter.
- If all cells are on fire, no spawn; the counter holds at GOLD_GAP and the scan retries each tick.
REQ-011 The spawn pointer SHALL increment modulo CELLS on every PLAY tick.
REQ-012 Gold expiry: gold clears after GOLD_LIFE ticks; gold and fire SHALL never share a cell.
REQ-013 Gold catch: on a non-tick PLAY cycle with (box & gold_state)!=0:
- score increments by 1, saturating at SCORE_MAX.
- gold_state clears next edge; the gap counter restarts at 0.
- super has no effect on catching.
REQ-014 Catch and hit on different cells in the same cycle SHALL both apply.
REQ-015 win SHALL set on entry to FINISH iff score==SCORE_MAX; otherwise it stays 0.
REQ-016 life==0 and score==SCORE_MAX reached together SHALL give FINISH with win=1.

Reset
REQ-017 rst_n low SHALL immediately set every register to its REQ-005 value, game_state=INIT and hit_pulse=0, regardless of state.
REQ-018 Release of rst_n SHALL leave the block in INIT; operation resumes on the first edge after release.

Verification
REQ-019 Reset mid-PLAY (life=1, score=3) -> immediate INIT, life=3, score=0, fire_state=100110110.
REQ-020 PLAY, one tick, defaults -> fire_state=010011011 next cycle; PAUSE then tick -> unchanged.
REQ-021 box=000000010 on fire, held 5 cycles, no tick -> life 3->2 once, single hit_pulse, fire_state[1]=0 until next tick.
REQ-022 box covering 3 fire cells, life=2 -> life=0, FINISH next cycle, win=0; repeat with super=1 -> life unchanged.
REQ-023 Five gold catches -> score=5, FINISH, win=1; then start -> INIT.
REQ-024 Force all-fire pattern (SEED all ones, TAPS=0) -> gold_state stays 0 across 10 ticks, gap counter holds.
